// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, bit period CLKDIV+1 clocks, with ready/ack handshake and error status.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at each sample point.
module uart_rx #(
  parameter int CLKDIV = 128,
  parameter int WIDTH  = $clog2(CLKDIV + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int BITCYC = CLKDIV + 1;
  localparam logic [WIDTH-1:0] HALF = WIDTH'(BITCYC / 2);
`ifdef UART_RX_MAJORITY_EN
  // The vote adds one cycle after expiry, so the reload is one shorter to keep the bit period.
  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(CLKDIV - 1);
`else
  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(CLKDIV);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift;
  logic             rx_meta, rx_s;
  logic             in_frame, tick, bit_val;
  logic             take_bit, good_stop, bad_stop;

  // Synchronizer presets high so a low line during reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking so rx_s takes the previous rx_meta, giving two real flop stages.
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
    end
  end

  assign in_frame = (state == START) || (state == DATA) || (state == STOP);

`ifdef UART_RX_MAJORITY_EN
  logic s_c1, s_c0, pend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_c1 <= 1'b1;
      s_c0 <= 1'b1;
      pend <= 1'b0;
    end else begin
      if (cnt == WIDTH'(1)) s_c1 <= rx_s;
      if (cnt == '0)        s_c0 <= rx_s;
      pend <= in_frame && (cnt == '0) && !pend;
    end
  end

  assign tick    = pend;
  assign bit_val = (s_c1 & s_c0) | (s_c1 & rx_s) | (s_c0 & rx_s);
`else
  assign tick    = in_frame && (cnt == '0);
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path infers a latch.
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    take_bit  = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    if (in_frame && cnt != '0) cnt_n = cnt - 1'b1;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n   = HALF;
      end
      START: if (tick) begin
        if (bit_val) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          cnt_n   = RELOAD;
          idx_n   = '0;
        end
      end
      DATA: if (tick) begin
        take_bit = 1'b1;
        cnt_n    = RELOAD;
        idx_n    = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (tick) begin
        if (bit_val) begin
          good_stop = 1'b1;
          state_n   = IDLE;
        end else begin
          bad_stop  = 1'b1;
          state_n   = BREAK;
        end
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift        <= '0;
      rx_data      <= '0;
      rx_ready     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_frame_err <= bad_stop;
      if (take_bit) shift[idx] <= bit_val;
      if (good_stop) begin
        rx_data    <= shift;
        rx_ready   <= 1'b1;
        // An ack in the completion cycle consumed the old byte, so nothing was lost.
        rx_overrun <= rx_ready && !rx_ack;
      end else if (rx_ack && rx_ready) begin
        rx_ready   <= 1'b0;
        rx_overrun <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKDIV=15 (16-clock bits).
module tb_uart_rx;

  localparam int CLKDIV = 15;
  localparam int BIT    = CLKDIV + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Stop-bit decision edge counted from the negedge that drives the start bit.
  localparam int STOP_EDGE = 156 + MAJ;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_ready, rx_overrun, rx_frame_err, rx_busy;

  int n_vec  = 0;
  int n_miss = 0;
  int ferr_cnt = 0;
  int busy_cnt = 0;

  uart_rx #(.CLKDIV(CLKDIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_frame_err) ferr_cnt++;
    if (rx_busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int glitch);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int c = 0; c < 10 * BIT; c++) begin
      @(negedge clk);
      rx_pin = fr[c / BIT] ^ (c == glitch);
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rx_pin = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_ready", rx_ready, 1'b0);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_ferr", rx_frame_err, 1'b0);
    check("rst_busy", rx_busy, 1'b0);

    // Single clean byte.
    ferr_cnt = 0;
    send_frame(8'hA5, 1'b1, -1);
    repeat (2) @(negedge clk);
    check("a5_ready", rx_ready, 1'b1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_overrun", rx_overrun, 1'b0);
    check("a5_ferr_cnt", ferr_cnt, 0);
    pulse_ack();
    check("a5_ack_ready", rx_ready, 1'b0);
    check("a5_ack_data", rx_data, 8'hA5);

    // Back-to-back frames without ack.
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    repeat (2) @(negedge clk);
    check("b2b_data", rx_data, 8'hC3);
    check("b2b_ready", rx_ready, 1'b1);
    check("b2b_overrun", rx_overrun, 1'b1);
    pulse_ack();
    check("b2b_ack_ready", rx_ready, 1'b0);
    check("b2b_ack_overrun", rx_overrun, 1'b0);
    pulse_ack();
    check("idle_ack_ready", rx_ready, 1'b0);

    // Three-clock low glitch: false start.
    repeat (4) @(negedge clk);
    busy_cnt = 0;
    ferr_cnt = 0;
    rx_pin = 1'b0;
    repeat (3) @(negedge clk);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_len", busy_cnt, 9 + MAJ);
    check("glitch_busy", rx_busy, 1'b0);
    check("glitch_ready", rx_ready, 1'b0);
    check("glitch_ferr", ferr_cnt, 0);

    // Bad stop bit followed by a long break.
    ferr_cnt = 0;
    send_frame(8'h55, 1'b0, -1);
    repeat (20 * BIT) @(negedge clk);
    check("brk_ferr_cnt", ferr_cnt, 1);
    check("brk_busy", rx_busy, 1'b1);
    check("brk_ready", rx_ready, 1'b0);
    check("brk_data", rx_data, 8'hC3);
    check("brk_overrun", rx_overrun, 1'b0);
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_exit_busy", rx_busy, 1'b0);
    check("brk_exit_ferr", ferr_cnt, 1);

    // Ack on the exact completion cycle of the second byte.
    send_frame(8'h11, 1'b1, -1);
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        repeat (STOP_EDGE) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    check("ackc_ready", rx_ready, 1'b1);
    check("ackc_overrun", rx_overrun, 1'b0);
    check("ackc_data", rx_data, 8'h22);
    pulse_ack();

    // Reset in the middle of data bit 4, then a clean byte.
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (5 * BIT + BIT / 2) @(negedge clk);
    rst = 1'b0;
    rx_pin = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("mid_rst_busy", rx_busy, 1'b0);
    check("mid_rst_ready", rx_ready, 1'b0);
    check("mid_rst_data", rx_data, 8'h00);
    ferr_cnt = 0;
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h81, 1'b1, 57);
`else
    send_frame(8'h81, 1'b1, -1);
`endif
    repeat (2) @(negedge clk);
    check("x81_data", rx_data, 8'h81);
    check("x81_ready", rx_ready, 1'b1);
    check("x81_ferr", ferr_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
